// File: rtl/beat_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | beat_sequencer                                                             |
// | Music beat sequencer: track select, tempo divide, play/fade/idle volume    |
// | ramp, plus an independent one-shot sound-effect beat counter.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module beat_sequencer #(
  parameter int TRACK0_LEN = 1200,
  parameter int TRACK1_LEN = 512,
  parameter int TRACK2_LEN = 256,
  parameter int TRACK3_LEN = 64,
  parameter int SFX_LEN    = 16,
  parameter int FADE_STEP  = 8
) (
  input  logic        clk22,
  input  logic        rst,
  input  logic        play_en,
  input  logic [1:0]  track_sel,
  input  logic [2:0]  tempo_div,
  input  logic [1:0]  vol_in,
  input  logic        sfx_req,
  output logic [11:0] beat_num,
  output logic        music_en,
  output logic [1:0]  volume,
  output logic        sfx_active,
  output logic [5:0]  sfx_beat,
  output logic        loop_done,
  output logic [1:0]  seq_state
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_PLAY = 2'd1;
  localparam logic [1:0] C_FADE = 2'd2;

  localparam int              C_FW        = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
  localparam logic [C_FW-1:0] C_FADE_LAST = C_FW'(FADE_STEP - 1);
  localparam logic [11:0]     C_LEN0_M1   = 12'(TRACK0_LEN - 1);
  localparam logic [11:0]     C_LEN1_M1   = 12'(TRACK1_LEN - 1);
  localparam logic [11:0]     C_LEN2_M1   = 12'(TRACK2_LEN - 1);
  localparam logic [11:0]     C_LEN3_M1   = 12'(TRACK3_LEN - 1);
  localparam logic [5:0]      C_SFX_LAST  = 6'(SFX_LEN - 1);

  logic            r_play_s1, r_play_s2;
  logic            r_sfx_s1, r_sfx_s2, r_sfx_prev;
  logic [1:0]      r_trk_s1, r_trk_s2;
  logic [1:0]      r_state;
  logic [1:0]      r_cur_track;
  logic [11:0]     r_beat;
  logic [2:0]      r_tick;
  logic [C_FW-1:0] r_fade_cnt;
  logic [1:0]      r_vol;
  logic            r_pending;
  logic            r_loop_done;
  logic            r_sfx_active;
  logic [5:0]      r_sfx_beat;

  logic [11:0]     w_len_m1;
  logic            w_tick_hit;
  logic            w_wrap;
  logic [11:0]     w_beat_adv;
  logic            w_fade_term;
  logic            w_sfx_rise;

  // Two-flop synchronisers; r_sfx_prev is the edge-detect history
  always_ff @(posedge clk22 or posedge rst) begin
    if (rst) begin
      r_play_s1  <= 1'b0;
      r_play_s2  <= 1'b0;
      r_sfx_s1   <= 1'b0;
      r_sfx_s2   <= 1'b0;
      r_sfx_prev <= 1'b0;
      r_trk_s1   <= 2'd0;
      r_trk_s2   <= 2'd0;
    end else begin
      r_play_s1  <= play_en;
      r_play_s2  <= r_play_s1;
      r_sfx_s1   <= sfx_req;
      r_sfx_s2   <= r_sfx_s1;
      r_sfx_prev <= r_sfx_s2;
      r_trk_s1   <= track_sel;
      r_trk_s2   <= r_trk_s1;
    end
  end

  always_comb begin
    w_len_m1 = C_LEN0_M1;
    case (r_cur_track)
      2'd0:    w_len_m1 = C_LEN0_M1;
      2'd1:    w_len_m1 = C_LEN1_M1;
      2'd2:    w_len_m1 = C_LEN2_M1;
      default: w_len_m1 = C_LEN3_M1;
    endcase
  end

  // >= so a tempo_div lowered below the running count still ends the beat
  assign w_tick_hit  = (r_tick >= tempo_div);
  assign w_wrap      = (r_beat == w_len_m1);
  assign w_beat_adv  = w_wrap ? 12'd0 : r_beat + 12'd1;
  assign w_fade_term = (r_fade_cnt == C_FADE_LAST);
  assign w_sfx_rise  = r_sfx_s2 & ~r_sfx_prev;

  always_ff @(posedge clk22 or posedge rst) begin
    if (rst) begin
      r_state     <= C_IDLE;
      r_cur_track <= 2'd0;
      r_beat      <= 12'd0;
      r_tick      <= 3'd0;
      r_fade_cnt  <= '0;
      r_vol       <= 2'd0;
      r_pending   <= 1'b0;
      r_loop_done <= 1'b0;
    end else begin
      r_loop_done <= 1'b0;
      // Beat clock runs identically in PLAY and FADE; state branches override below
      if (r_state == C_PLAY || r_state == C_FADE) begin
        if (w_tick_hit) begin
          r_tick      <= 3'd0;
          r_beat      <= w_beat_adv;
          r_loop_done <= w_wrap;
        end else begin
          r_tick <= r_tick + 3'd1;
        end
      end
      case (r_state)
        C_IDLE: begin
          r_beat     <= 12'd0;
          r_vol      <= 2'd0;
          r_tick     <= 3'd0;
          r_fade_cnt <= '0;
          if (r_play_s2) begin
            r_state     <= C_PLAY;
            r_cur_track <= r_trk_s2;
            r_vol       <= vol_in;
          end
        end
        C_PLAY: begin
          r_vol      <= vol_in;
          r_fade_cnt <= '0;
          if (!r_play_s2) begin
            r_state   <= C_FADE;
            r_pending <= 1'b0;
          end else if (r_trk_s2 != r_cur_track) begin
            r_state   <= C_FADE;
            r_pending <= 1'b1;
          end
        end
        C_FADE: begin
          if (r_play_s2 && !r_pending) begin
            r_state <= C_PLAY;
            r_vol   <= vol_in;
          end else if (w_fade_term) begin
            r_fade_cnt <= '0;
            if (r_vol != 2'd0) begin
              r_vol <= r_vol - 2'd1;
            end else if (r_pending && r_play_s2) begin
              r_state     <= C_PLAY;
              r_beat      <= 12'd0;
              r_tick      <= 3'd0;
              r_cur_track <= r_trk_s2;
              r_vol       <= vol_in;
              r_pending   <= 1'b0;
            end else begin
              r_state   <= C_IDLE;
              r_beat    <= 12'd0;
              r_tick    <= 3'd0;
              r_pending <= 1'b0;
            end
          end else begin
            r_fade_cnt <= r_fade_cnt + 1'b1;
          end
          if (!r_play_s2) begin
            r_pending <= 1'b0;
          end
        end
        default: begin
          r_state <= C_IDLE;
        end
      endcase
    end
  end

  // Sound-effect counter runs every cycle regardless of the music state
  always_ff @(posedge clk22 or posedge rst) begin
    if (rst) begin
      r_sfx_active <= 1'b0;
      r_sfx_beat   <= 6'd0;
    end else if (w_sfx_rise) begin
      r_sfx_active <= 1'b1;
      r_sfx_beat   <= 6'd0;
    end else if (r_sfx_active) begin
      if (r_sfx_beat == C_SFX_LAST) begin
        r_sfx_active <= 1'b0;
        r_sfx_beat   <= 6'd0;
      end else begin
        r_sfx_beat <= r_sfx_beat + 6'd1;
      end
    end
  end

  assign beat_num   = r_beat;
  assign music_en   = (r_state == C_PLAY) || (r_state == C_FADE);
  assign volume     = r_vol;
  assign sfx_active = r_sfx_active;
  assign sfx_beat   = r_sfx_beat;
  assign loop_done  = r_loop_done;
  assign seq_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_beat_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_beat_sequencer                                                          |
// | Self-checking bench for beat_sequencer: vector table plus scoreboard queue.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_beat_sequencer;

  logic        clk22;
  logic        rst;
  logic        play_en;
  logic [1:0]  track_sel;
  logic [2:0]  tempo_div;
  logic [1:0]  vol_in;
  logic        sfx_req;
  logic [11:0] beat_num;
  logic        music_en;
  logic [1:0]  volume;
  logic        sfx_active;
  logic [5:0]  sfx_beat;
  logic        loop_done;
  logic [1:0]  seq_state;

  beat_sequencer dut (
    .clk22      (clk22),
    .rst        (rst),
    .play_en    (play_en),
    .track_sel  (track_sel),
    .tempo_div  (tempo_div),
    .vol_in     (vol_in),
    .sfx_req    (sfx_req),
    .beat_num   (beat_num),
    .music_en   (music_en),
    .volume     (volume),
    .sfx_active (sfx_active),
    .sfx_beat   (sfx_beat),
    .loop_done  (loop_done),
    .seq_state  (seq_state)
  );

  initial clk22 = 1'b0;
  always #5 clk22 = ~clk22;

  typedef struct {
    int n;
    int state;
    int beat;
    int ld;
    int vol;
  } vec_t;

  typedef struct {
    int beat;
    int ld;
    int chk_sfx;
    int act;
    int sb;
  } exp_t;

  int   n_total  = 0;
  int   n_passed = 0;
  exp_t sb_q[$];
  vec_t vtab[13];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk22);
    #1;
  endtask

  // Expectation queued with the stimulus, retired once the DUT has clocked
  task automatic sb_cycle(input exp_t e);
    exp_t got;
    sb_q.push_back(e);
    cyc(1);
    got = sb_q.pop_front();
    chk("sb_beat", int'(beat_num), got.beat);
    chk("sb_loop_done", int'(loop_done), got.ld);
    if (got.chk_sfx != 0) begin
      chk("sb_sfx_active", int'(sfx_active), got.act);
      chk("sb_sfx_beat", int'(sfx_beat), got.sb);
    end
  endtask

  task automatic release_rst();
    @(posedge clk22);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cur;
    int   pulses;
    exp_t e;

    // Beats counted from the third edge after release, tempo_div=3, track 1 (len 512)
    vtab[0]  = '{2,    0, 0,   0, 0};
    vtab[1]  = '{3,    1, 0,   0, 1};
    vtab[2]  = '{6,    1, 0,   0, 1};
    vtab[3]  = '{7,    1, 1,   0, 1};
    vtab[4]  = '{10,   1, 1,   0, 1};
    vtab[5]  = '{11,   1, 2,   0, 1};
    vtab[6]  = '{403,  1, 100, 0, 1};
    vtab[7]  = '{2046, 1, 510, 0, 1};
    vtab[8]  = '{2047, 1, 511, 0, 1};
    vtab[9]  = '{2050, 1, 511, 0, 1};
    vtab[10] = '{2051, 1, 0,   1, 1};
    vtab[11] = '{2052, 1, 0,   0, 1};
    vtab[12] = '{2055, 1, 1,   0, 1};

    rst = 1'b1; play_en = 1'b1; track_sel = 2'd3; tempo_div = 3'd0;
    vol_in = 2'd2; sfx_req = 1'b0;

    // ---- 1: track 3, tempo 0 ----
    #12;
    chk("rst_state", int'(seq_state), 0);
    chk("rst_beat", int'(beat_num), 0);
    chk("rst_volume", int'(volume), 0);
    chk("rst_music_en", int'(music_en), 0);
    chk("rst_sfx_active", int'(sfx_active), 0);
    chk("rst_loop_done", int'(loop_done), 0);
    release_rst();
    cyc(2);
    chk("t1_state_edge2", int'(seq_state), 0);
    cyc(1);
    chk("t1_state_edge3", int'(seq_state), 1);
    chk("t1_music_en", int'(music_en), 1);
    chk("t1_volume", int'(volume), 2);
    chk("t1_beat0", int'(beat_num), 0);
    pulses = 0;
    for (int k = 1; k <= 130; k++) begin
      e = '{k % 64, (k % 64 == 0) ? 1 : 0, 0, 0, 0};
      sb_cycle(e);
      if (loop_done) pulses++;
    end
    chk("t1_loop_pulses", pulses, 2);

    // ---- 2: track 1, tempo 3 ----
    rst = 1'b1; track_sel = 2'd1; tempo_div = 3'd3; vol_in = 2'd1;
    #3;
    release_rst();
    cur = 0;
    for (int i = 0; i < 13; i++) begin
      cyc(vtab[i].n - cur);
      cur = vtab[i].n;
      chk($sformatf("t2_state_n%0d", vtab[i].n), int'(seq_state), vtab[i].state);
      chk($sformatf("t2_beat_n%0d", vtab[i].n), int'(beat_num), vtab[i].beat);
      chk($sformatf("t2_ld_n%0d", vtab[i].n), int'(loop_done), vtab[i].ld);
      chk($sformatf("t2_vol_n%0d", vtab[i].n), int'(volume), vtab[i].vol);
    end

    // ---- 3: fade to idle from volume 3 ----
    vol_in = 2'd3;
    cyc(1);
    chk("t3_vol_track", int'(volume), 3);
    play_en = 1'b0;
    cyc(2);
    chk("t3_still_play", int'(seq_state), 1);
    cyc(1);
    chk("t3_fade_state", int'(seq_state), 2);
    chk("t3_fade_music_en", int'(music_en), 1);
    cyc(7);
    chk("t3_vol_f7", int'(volume), 3);
    cyc(1);
    chk("t3_vol_f8", int'(volume), 2);
    cyc(8);
    chk("t3_vol_f16", int'(volume), 1);
    cyc(8);
    chk("t3_vol_f24", int'(volume), 0);
    chk("t3_state_f24", int'(seq_state), 2);
    cyc(7);
    chk("t3_state_f31", int'(seq_state), 2);
    chk("t3_beat_f31", int'(beat_num), 9);
    cyc(1);
    chk("t3_idle_state", int'(seq_state), 0);
    chk("t3_idle_beat", int'(beat_num), 0);
    chk("t3_idle_music_en", int'(music_en), 0);

    // ---- 4: track change fade, then abort fade ----
    rst = 1'b1; play_en = 1'b1; track_sel = 2'd0; tempo_div = 3'd0; vol_in = 2'd2;
    #3;
    release_rst();
    cyc(3);
    chk("t4_play", int'(seq_state), 1);
    cyc(10);
    chk("t4_beat10", int'(beat_num), 10);
    track_sel = 2'd2;
    cyc(2);
    chk("t4_pre_fade", int'(seq_state), 1);
    cyc(1);
    chk("t4_fade", int'(seq_state), 2);
    chk("t4_fade_beat", int'(beat_num), 13);
    chk("t4_fade_vol", int'(volume), 2);
    cyc(8);
    chk("t4_vol_f8", int'(volume), 1);
    cyc(8);
    chk("t4_vol_f16", int'(volume), 0);
    cyc(7);
    chk("t4_state_f23", int'(seq_state), 2);
    chk("t4_beat_f23", int'(beat_num), 36);
    cyc(1);
    chk("t4_new_play", int'(seq_state), 1);
    chk("t4_new_beat", int'(beat_num), 0);
    chk("t4_new_vol", int'(volume), 2);
    cyc(5);
    chk("t4_trk2_beat5", int'(beat_num), 5);
    play_en = 1'b0;
    cyc(3);
    chk("t4_abort_fade", int'(seq_state), 2);
    chk("t4_abort_fade_beat", int'(beat_num), 8);
    cyc(2);
    play_en = 1'b1; vol_in = 2'd1;
    cyc(2);
    chk("t4_abort_wait_state", int'(seq_state), 2);
    chk("t4_abort_wait_vol", int'(volume), 2);
    cyc(1);
    chk("t4_abort_state", int'(seq_state), 1);
    chk("t4_abort_vol", int'(volume), 1);
    chk("t4_abort_beat", int'(beat_num), 13);

    // ---- 5: sound effect and retrigger; music beat = 13 + j ----
    sfx_req = 1'b1;
    for (int j = 1; j <= 50; j++) begin
      e = '{13 + j, 0, 1, 0, 0};
      if (j >= 3 && j <= 18) begin e.act = 1; e.sb = j - 3; end
      else if (j >= 25 && j <= 32) begin e.act = 1; e.sb = j - 25; end
      else if (j >= 33 && j <= 48) begin e.act = 1; e.sb = j - 33; end
      sb_cycle(e);
      if (j == 4)  sfx_req = 1'b0;
      if (j == 22) sfx_req = 1'b1;
      if (j == 23) sfx_req = 1'b0;
      if (j == 30) sfx_req = 1'b1;
    end

    // ---- 6: asynchronous reset mid-fade with sfx running ----
    play_en = 1'b0; sfx_req = 1'b0;
    cyc(1);
    sfx_req = 1'b1;
    cyc(2);
    chk("t6_fade", int'(seq_state), 2);
    cyc(1);
    chk("t6_sfx_on", int'(sfx_active), 1);
    cyc(1);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_state", int'(seq_state), 0);
    chk("t6_rst_beat", int'(beat_num), 0);
    chk("t6_rst_vol", int'(volume), 0);
    chk("t6_rst_music_en", int'(music_en), 0);
    chk("t6_rst_sfx_active", int'(sfx_active), 0);
    chk("t6_rst_sfx_beat", int'(sfx_beat), 0);
    chk("t6_rst_loop_done", int'(loop_done), 0);
    sfx_req = 1'b0; play_en = 1'b1; track_sel = 2'd3; vol_in = 2'd2; tempo_div = 3'd0;
    release_rst();
    cyc(2);
    chk("t6_restart_idle", int'(seq_state), 0);
    cyc(1);
    chk("t6_restart_play", int'(seq_state), 1);
    chk("t6_restart_vol", int'(volume), 2);
    cyc(2);
    chk("t6_restart_beat", int'(beat_num), 2);
    chk("t6_restart_sfx", int'(sfx_active), 0);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
`default_nettype wire
